// File: rtl/player_pkg.sv
// player_pkg: shared state type and screen/sprite geometry for the player controller
package player_pkg;
    typedef enum logic [1:0] {GROUND, JUMP, FALL} player_state_t;
    localparam int SPRITE_W   = 64;
    localparam int SCREEN_W   = 1024;
    localparam int X_START_D  = 10;
    localparam int Y_GROUND_D = 100 + SPRITE_W * 3;
endpackage

// File: rtl/player_ctl_frame_tick.sv
// frame_tick: one-cycle pulse on each rising edge of vsync
module frame_tick (
    input  logic clk,
    input  logic rst,
    input  logic vsync_in,
    output logic tick
);
    logic vsync_d;
    always_ff @(posedge clk or negedge rst)
        if (!rst) vsync_d <= 1'b0;
        else      vsync_d <= vsync_in;
    assign tick = vsync_in & ~vsync_d;
endmodule

// File: rtl/player_ctl.sv
// player_ctl: per-frame walk and jump/fall motion of the player sprite
module player_ctl
    import player_pkg::*;
#(
    parameter int X_START   = X_START_D,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = SCREEN_W - SPRITE_W,
    parameter int Y_GROUND  = Y_GROUND_D,
    parameter int Y_MIN     = 0,
    parameter int WALK_STEP = 2,
    parameter int JUMP_V0   = 12,
    parameter int GRAVITY   = 1,
    parameter int V_MAX     = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync_in,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    output logic [9:0] player_xpos,
    output logic [9:0] player_ypos,
    output logic       dirction,
    output logic       airborne
);
    localparam logic [10:0] XMN = 11'(X_MIN);
    localparam logic [10:0] XMX = 11'(X_MAX);
    localparam logic [10:0] WS  = 11'(WALK_STEP);
    localparam logic [10:0] YMN = 11'(Y_MIN);
    localparam logic [10:0] YG  = 11'(Y_GROUND);
    localparam logic [4:0]  V0  = 5'(JUMP_V0);
    localparam logic [4:0]  G   = 5'(GRAVITY);
    localparam logic [4:0]  VMX = 5'(V_MAX);

    player_state_t state, state_n;
    logic [4:0]  vy, vy_n, vy_dec, vn;
    logic [9:0]  x_n, y_n;
    logic        dir_n, jump_prev, tick, hit, land;
    logic [10:0] x11, y11, x_r, x_l, y_up, y_dn;

    frame_tick u_tick (.clk(clk), .rst(rst), .vsync_in(vsync_in), .tick(tick));

    // 11-bit arithmetic keeps saturation free of wrap-around
    assign x11    = {1'b0, player_xpos};
    assign y11    = {1'b0, player_ypos};
    assign x_r    = (x11 + WS > XMX) ? XMX : x11 + WS;
    assign x_l    = (x11 < XMN + WS) ? XMN : x11 - WS;
    assign hit    = y11 <= YMN + {6'd0, vy};
    assign y_up   = hit ? YMN : y11 - {6'd0, vy};
    assign vy_dec = vy - G;
    assign vn     = (vy + G > VMX) ? VMX : vy + G;
    assign y_dn   = y11 + {6'd0, vn};
    assign land   = y_dn >= YG;

    always_comb begin
        state_n = state;
        vy_n    = vy;
        y_n     = player_ypos;
        x_n     = (btn_right && !btn_left) ? x_r[9:0] : (btn_left && !btn_right) ? x_l[9:0] : player_xpos;
        dir_n   = (btn_right && !btn_left) ? 1'b1 : (btn_left && !btn_right) ? 1'b0 : dirction;
        case (state)
            GROUND: if (btn_jump && !jump_prev) begin
                state_n = JUMP;
                vy_n    = V0;
            end
            JUMP: begin
                y_n     = y_up[9:0];
                vy_n    = hit ? 5'd0 : vy_dec;
                state_n = (hit || vy_dec == 5'd0) ? FALL : JUMP;
            end
            FALL: begin
                y_n     = land ? YG[9:0] : y_dn[9:0];
                vy_n    = land ? 5'd0 : vn;
                state_n = land ? GROUND : FALL;
            end
            default: state_n = GROUND;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state       <= GROUND;
            vy          <= 5'd0;
            jump_prev   <= 1'b1;
            player_xpos <= 10'(X_START);
            player_ypos <= 10'(Y_GROUND);
            dirction    <= 1'b1;
            airborne    <= 1'b0;
        end else if (tick) begin
            state       <= state_n;
            vy          <= vy_n;
            jump_prev   <= btn_jump;
            player_xpos <= x_n;
            player_ypos <= y_n;
            dirction    <= dir_n;
            airborne    <= state_n != GROUND;
        end
endmodule

// File: tb/tb_player_ctl.sv
// tb_player_ctl: randomized and directed checks of player_ctl against a closed-form trajectory model
module tb_player_ctl;
    logic       clk = 0, rst = 0, vsync_in = 0;
    logic       btn_left = 0, btn_right = 0, btn_jump = 0;
    logic [9:0] player_xpos, player_ypos;
    logic       dirction, airborne;
    int checks = 0, errors = 0;
    int mx, my, ma;
    bit mdir, mprev;

    player_ctl dut (
        .clk(clk), .rst(rst), .vsync_in(vsync_in),
        .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
        .player_xpos(player_xpos), .player_ypos(player_ypos),
        .dirction(dirction), .airborne(airborne)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // height after the a-th tick of a jump: 12,11,..,1 up then 1,2,..,12 down
    function automatic int y_of(input int a);
        int j, m;
        if (a <= 1) return 292;
        if (a <= 13) begin
            j = a - 1;
            return 292 - (12 * j - j * (j - 1) / 2);
        end
        m = a - 13;
        return 214 + m * (m + 1) / 2;
    endfunction

    task automatic model_reset();
        mx = 10; my = 292; mdir = 1; ma = 0; mprev = 1;
    endtask

    task automatic model_tick(input bit l, input bit r, input bit j);
        if (r && !l) begin
            mx = (mx + 2 > 960) ? 960 : mx + 2;
            mdir = 1;
        end else if (l && !r) begin
            mx = (mx < 2) ? 0 : mx - 2;
            mdir = 0;
        end
        if (ma > 0) ma++;
        else if (j && !mprev) ma = 1;
        if (ma == 25) ma = 0;
        mprev = j;
        my = y_of(ma);
    endtask

    task automatic check_all(input string pfx);
        check({pfx, "_x"}, int'(player_xpos), mx);
        check({pfx, "_y"}, int'(player_ypos), my);
        check({pfx, "_dir"}, int'(dirction), int'(mdir));
        check({pfx, "_air"}, int'(airborne), int'(ma != 0));
    endtask

    task automatic frame(input bit l, input bit r, input bit j);
        @(negedge clk);
        btn_left = l; btn_right = r; btn_jump = j; vsync_in = 1;
        @(posedge clk);
        model_tick(l, r, j);
        @(negedge clk);
        check_all("tick");
        @(negedge clk);
        vsync_in = 0;
        btn_left = 1'($urandom); btn_right = 1'($urandom); btn_jump = 1'($urandom);
        @(negedge clk);
        @(negedge clk);
        check_all("hold");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        #1;
        model_reset();
        check_all("rst_async");
        @(negedge clk);
        rst = 1;
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1;
        repeat (5) frame(0, 1, 0);
        check("walk5_x", int'(player_xpos), 20);
        while (mx < 958) frame(0, 1, 0);
        repeat (3) frame(0, 1, 0);
        check("clamp_hi", int'(player_xpos), 960);
        while (mx > 0) frame(1, 0, 0);
        repeat (3) frame(1, 0, 0);
        check("clamp_lo", int'(player_xpos), 0);
        check("clamp_lo_dir", int'(dirction), 0);
        repeat (4) frame(1, 1, 0);
        frame(0, 0, 1);
        check("jump_start_y", int'(player_ypos), 292);
        repeat (12) frame(0, 0, 0);
        check("apex_y", int'(player_ypos), 214);
        repeat (11) frame(0, 0, 0);
        check("still_air", int'(airborne), 1);
        frame(0, 0, 0);
        check("landed_air", int'(airborne), 0);
        check("landed_y", int'(player_ypos), 292);
        repeat (35) frame(0, 0, 1);
        check("held_no_rejump", int'(airborne), 0);
        frame(0, 0, 0);
        frame(0, 0, 1);
        check("rejump_air", int'(airborne), 1);
        repeat (5) frame(0, 1, 0);
        do_reset();
        for (int i = 0; i < 400; i++)
            frame(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
        frame(0, 0, 0);
        frame(0, 0, 1);
        repeat (3) frame(1, 0, 0);
        do_reset();
        repeat (20) frame(1'($urandom), 1'($urandom), 1'($urandom));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
